// File: rtl/cordic_mul_pkg.sv
// Shared types, widths and constant helpers for the linear-mode CORDIC multiplier sequencer.
package cordic_mul_pkg;

    localparam int unsigned WIDTH = 16;   // operand/result width, fixed to the adder width
    localparam int unsigned FRAC  = 14;   // Q1.14 fraction bits of x, y and z
    localparam int unsigned IW    = 5;    // iteration counter width, covers 0..FRAC

    typedef enum logic [1:0] {
        IDLE,
        STEP_Y,
        STEP_Z,
        DONE
    } cordic_state_t;

    // Exact two's complement negation with wrap: -(-32768) stays -32768.
    function automatic logic [WIDTH-1:0] neg_wrap(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Residual-angle step for iteration i: 1 << (FRAC - i).
    function automatic logic [WIDTH-1:0] z_const(input logic [IW-1:0] i);
        return WIDTH'(1) << (IW'(FRAC) - i);
    endfunction

endpackage

// File: rtl/cordic_mul_seq_if.sv
// Operand/result handshakes plus the port pair toward the shared external adder.
interface cordic_mul_seq_if;
    import cordic_mul_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_z;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_ovf;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   add_sum;

    // The sequencer side.
    modport slave (
        input  in_valid, in_x, in_z, out_ready, add_sum,
        output in_ready, out_valid, out_y, out_ovf, add_a, add_b
    );

    // The environment side: operand source, result sink and the adder itself.
    modport master (
        output in_valid, in_x, in_z, out_ready, add_sum,
        input  in_ready, out_valid, out_y, out_ovf, add_a, add_b
    );

endinterface

// File: rtl/cordic_mul_seq.sv
// Linear-mode CORDIC multiplier sequencer: time-shares one external adder between
// the y (accumulate) and z (residual) updates, two cycles per iteration.
module cordic_mul_seq
    import cordic_mul_pkg::*;
#(
    parameter int unsigned ITER = 15
) (
    input  logic             clk,
    input  logic             rst,
    cordic_mul_seq_if.slave  bus
);

    cordic_state_t    state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [IW-1:0]    i_q, i_d;
    logic             neg_q, neg_d;      // direction d = -1 when set
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] add_a_c;
    logic [WIDTH-1:0] add_b_c;
    logic [WIDTH-1:0] shx_c;
    logic [WIDTH-1:0] zc_c;
    logic             sum_ovf_c;

    // Next-state, datapath updates and adder operand selection.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        i_d         = i_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        add_a_c     = '0;
        add_b_c     = '0;
        shx_c       = WIDTH'($signed(x_q) >>> i_q);
        zc_c        = z_const(i_q);
        sum_ovf_c   = bus.add_sum[WIDTH] ^ bus.add_sum[WIDTH-1];

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.in_x;
                    z_d     = bus.in_z;
                    y_d     = '0;
                    i_d     = '0;
                    ovf_d   = 1'b0;
                    state_d = STEP_Y;
                end
            end
            STEP_Y: begin
                // Direction is sampled here and reused by the following z step.
                neg_d   = z_q[WIDTH-1];
                add_a_c = y_q;
                add_b_c = neg_d ? neg_wrap(shx_c) : shx_c;
                y_d     = bus.add_sum[WIDTH-1:0];
                ovf_d   = ovf_q | sum_ovf_c;
                state_d = STEP_Z;
            end
            STEP_Z: begin
                add_a_c = z_q;
                add_b_c = neg_q ? zc_c : neg_wrap(zc_c);
                z_d     = bus.add_sum[WIDTH-1:0];
                ovf_d   = ovf_q | sum_ovf_c;
                if (i_q == IW'(ITER - 1)) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + IW'(1);
                    state_d = STEP_Y;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            i_q         <= '0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            i_q         <= i_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = y_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.add_a     = add_a_c;
    assign bus.add_b     = add_b_c;

endmodule
